// File: rtl/toy_mem_arbiter_if.sv
// Requester-side port of toy_mem_arbiter: one request channel and one ack channel.
// No latency of its own; signals only.
// Each channel uses a valid/ready handshake; the payload is held until ready.
interface toy_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic                  req_vld;
  logic                  req_rdy;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W/8-1:0]   req_strb;
  logic [DATA_W-1:0]     req_data;
  logic                  req_opcode;
  logic [ID_W-1:0]       req_src_id;
  logic [ID_W-1:0]       req_tgt_id;
  logic                  ack_vld;
  logic                  ack_rdy;
  logic                  ack_opcode;
  logic [DATA_W-1:0]     ack_data;
  logic [ID_W-1:0]       ack_src_id;
  logic [ID_W-1:0]       ack_tgt_id;

  // Requester view
  modport master (
    output req_vld, req_addr, req_strb, req_data, req_opcode, req_src_id, req_tgt_id, ack_rdy,
    input  req_rdy, ack_vld, ack_opcode, ack_data, ack_src_id, ack_tgt_id
  );

  // Arbiter view
  modport slave (
    input  req_vld, req_addr, req_strb, req_data, req_opcode, req_src_id, req_tgt_id, ack_rdy,
    output req_rdy, ack_vld, ack_opcode, ack_data, ack_src_id, ack_tgt_id
  );
endinterface

// File: rtl/toy_mem_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between two requesters, one access in flight.
// Latency: request grant is same-cycle; the ack follows 1 cycle after a write, 2 after a read.
// Backpressure: req_rdy is low outside IDLE; the ack is held until ack_rdy, with no SRAM access meanwhile.
module toy_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  toy_mem_arbiter_if.slave     in0,
  toy_mem_arbiter_if.slave     in1,
  output logic                 mem_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_rd_data,
  output logic [DATA_W-1:0]    mem_wr_data,
  output logic [DATA_W/8-1:0]  mem_wr_byte_en,
  output logic                 mem_wr_en
);

  typedef enum logic [1:0] {IDLE, CAP, ACK} state_t;

  state_t              state;
  logic                rr_ptr;
  logic                owner;
  logic                ack_opcode_q;
  logic [DATA_W-1:0]   ack_data_q;
  logic [ID_W-1:0]     ack_src_q;
  logic [ID_W-1:0]     ack_tgt_q;

  logic                win;
  logic                grant;
  logic                ack_hs;
  logic                w_opcode;
  logic [ID_W-1:0]     w_src;
  logic [ID_W-1:0]     w_tgt;

  // Pick the winner: a lone requester wins, a tie goes to the round-robin pointer
  always_comb begin
    win = 1'b0;
    if (in0.req_vld && in1.req_vld) win = rr_ptr;
    else if (in1.req_vld)           win = 1'b1;
  end

  assign grant    = (state == IDLE) && (in0.req_vld || in1.req_vld);
  assign w_opcode = win ? in1.req_opcode : in0.req_opcode;
  assign w_src    = win ? in1.req_src_id : in0.req_src_id;
  assign w_tgt    = win ? in1.req_tgt_id : in0.req_tgt_id;

  assign in0.req_rdy = grant && !win;
  assign in1.req_rdy = grant &&  win;

  // The SRAM port sees the winning request directly in the grant cycle
  assign mem_en         = grant;
  assign mem_wr_en      = grant && w_opcode;
  assign mem_addr       = win ? in1.req_addr : in0.req_addr;
  assign mem_wr_data    = win ? in1.req_data : in0.req_data;
  assign mem_wr_byte_en = win ? in1.req_strb : in0.req_strb;

  assign ack_hs = (state == ACK) && (owner ? in1.ack_rdy : in0.ack_rdy);

  // Ack fields come from registers only; the non-owner never sees ack_vld
  assign in0.ack_vld    = (state == ACK) && !owner;
  assign in1.ack_vld    = (state == ACK) &&  owner;
  assign in0.ack_opcode = ack_opcode_q;
  assign in1.ack_opcode = ack_opcode_q;
  assign in0.ack_data   = ack_data_q;
  assign in1.ack_data   = ack_data_q;
  assign in0.ack_src_id = ack_src_q;
  assign in1.ack_src_id = ack_src_q;
  assign in0.ack_tgt_id = ack_tgt_q;
  assign in1.ack_tgt_id = ack_tgt_q;

  // Access FSM: capture the grant, wait one cycle for read data, then hold the ack until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= 1'b0;
      owner        <= 1'b0;
      ack_opcode_q <= 1'b0;
      ack_data_q   <= '0;
      ack_src_q    <= '0;
      ack_tgt_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            owner        <= win;
            rr_ptr       <= ~win;
            ack_opcode_q <= w_opcode;
            ack_src_q    <= w_tgt;
            ack_tgt_q    <= w_src;
            if (w_opcode) begin
              ack_data_q <= '0;
              state      <= ACK;
            end else begin
              state      <= CAP;
            end
          end
        end
        CAP: begin
          ack_data_q <= mem_rd_data;
          state      <= ACK;
        end
        ACK: begin
          if (ack_hs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_toy_mem_arbiter.sv
// Self-checking bench for toy_mem_arbiter: directed vectors, corner sequences, random traffic.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// A behavioural SRAM answers reads one cycle after the access strobe.
module tb_toy_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  toy_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) in0_if ();
  toy_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) in1_if ();

  logic [1:0]    req_vld;
  logic [1:0]    ack_rdy;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr [2];
  logic [SW-1:0] req_strb [2];
  logic [DW-1:0] req_data [2];
  logic [IW-1:0] req_src  [2];
  logic [IW-1:0] req_tgt  [2];

  assign in0_if.req_vld    = req_vld[0];
  assign in1_if.req_vld    = req_vld[1];
  assign in0_if.ack_rdy    = ack_rdy[0];
  assign in1_if.ack_rdy    = ack_rdy[1];
  assign in0_if.req_opcode = req_op[0];
  assign in1_if.req_opcode = req_op[1];
  assign in0_if.req_addr   = req_addr[0];
  assign in1_if.req_addr   = req_addr[1];
  assign in0_if.req_strb   = req_strb[0];
  assign in1_if.req_strb   = req_strb[1];
  assign in0_if.req_data   = req_data[0];
  assign in1_if.req_data   = req_data[1];
  assign in0_if.req_src_id = req_src[0];
  assign in1_if.req_src_id = req_src[1];
  assign in0_if.req_tgt_id = req_tgt[0];
  assign in1_if.req_tgt_id = req_tgt[1];

  wire [1:0] req_rdy = {in1_if.req_rdy, in0_if.req_rdy};
  wire [1:0] ack_vld = {in1_if.ack_vld, in0_if.ack_vld};
  wire [1:0] ack_op  = {in1_if.ack_opcode, in0_if.ack_opcode};
  logic [DW-1:0] ack_data [2];
  logic [IW-1:0] ack_src  [2];
  logic [IW-1:0] ack_tgt  [2];
  assign ack_data[0] = in0_if.ack_data;
  assign ack_data[1] = in1_if.ack_data;
  assign ack_src[0]  = in0_if.ack_src_id;
  assign ack_src[1]  = in1_if.ack_src_id;
  assign ack_tgt[0]  = in0_if.ack_tgt_id;
  assign ack_tgt[1]  = in1_if.ack_tgt_id;

  logic          mem_en;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [SW-1:0] mem_wr_byte_en;
  logic [DW-1:0] mem_rd_data = '0;

  toy_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk            (clk),
    .rst            (rst),
    .in0            (in0_if),
    .in1            (in1_if),
    .mem_en         (mem_en),
    .mem_addr       (mem_addr),
    .mem_rd_data    (mem_rd_data),
    .mem_wr_data    (mem_wr_data),
    .mem_wr_byte_en (mem_wr_byte_en),
    .mem_wr_en      (mem_wr_en)
  );

  // Behavioural single-port SRAM, 256 words, one-cycle read latency
  logic [DW-1:0] sram [256] = '{default: '0};
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr_en) begin
        for (int b = 0; b < SW; b++)
          if (mem_wr_byte_en[b]) sram[mem_addr[9:2]][8*b +: 8] <= mem_wr_data[8*b +: 8];
      end else begin
        mem_rd_data <= sram[mem_addr[9:2]];
      end
    end
  end

  // Completed ack handshakes per port
  int ack_cnt0 = 0;
  int ack_cnt1 = 0;
  always @(posedge clk) begin
    if (ack_vld[0] && ack_rdy[0]) ack_cnt0 <= ack_cnt0 + 1;
    if (ack_vld[1] && ack_rdy[1]) ack_cnt1 <= ack_cnt1 + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic op, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [SW-1:0] strb,
                         input logic [IW-1:0] src, input logic [IW-1:0] tgt);
    req_op[p]   = op;
    req_addr[p] = addr;
    req_data[p] = data;
    req_strb[p] = strb;
    req_src[p]  = src;
    req_tgt[p]  = tgt;
  endtask

  // Returns at the falling edge where port p first shows ack_vld; lat counts cycles after the grant
  task automatic wait_ack(input int p, input int max_c, output int lat);
    lat = -1;
    for (int c = 1; c <= max_c; c++) begin
      @(negedge clk);
      check("non_owner_ack_low", {63'd0, ack_vld[1-p]}, 64'd0);
      if (ack_vld[p]) begin
        lat = c;
        break;
      end
      tick();
    end
    if (lat < 0) check("ack_timeout", 64'd0, 64'd1);
  endtask

  typedef struct {
    int            port;
    logic          op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [IW-1:0] src;
    logic [IW-1:0] tgt;
    logic [DW-1:0] exp_data;
  } vec_t;

  typedef struct packed {
    logic          op;
    logic [DW-1:0] data;
    logic [IW-1:0] src;
    logic [IW-1:0] tgt;
  } ack_t;

  vec_t vecs [6];
  ack_t expq0 [$];
  ack_t expq1 [$];
  logic [DW-1:0] ref_mem [256] = '{default: '0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int base0;
    int base1;
    bit got;
    int ptr;
    logic [1:0] granted;
    int w;
    ack_t e;
    ack_t a;

    vecs[0] = '{1, 1'b1, 32'h80, 32'h11223344, 4'hF, 4'd5, 4'd6, 32'h0};
    vecs[1] = '{0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 4'd1, 4'd2, 32'h0};
    vecs[2] = '{1, 1'b0, 32'h40, 32'h0,        4'h0, 4'd3, 4'd5, 32'hDEADBEEF};
    vecs[3] = '{1, 1'b1, 32'h40, 32'h00001234, 4'h3, 4'd7, 4'd9, 32'h0};
    vecs[4] = '{0, 1'b1, 32'h44, 32'hCAFEF00D, 4'hC, 4'd2, 4'd8, 32'h0};
    vecs[5] = '{0, 1'b0, 32'h44, 32'h0,        4'h0, 4'd4, 4'd6, 32'hCAFE0000};

    req_vld = '0;
    ack_rdy = '0;
    for (int p = 0; p < 2; p++) set_req(p, 1'b0, '0, '0, '0, '0, '0);

    // Reset holds everything quiet
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("rst_req_rdy", {62'd0, req_rdy}, 64'd0);
    check("rst_ack_vld", {62'd0, ack_vld}, 64'd0);
    check("rst_mem_en", {63'd0, mem_en}, 64'd0);
    check("rst_mem_wr_en", {63'd0, mem_wr_en}, 64'd0);
    tick();
    rst = 1'b0;

    // Directed single-requester vectors
    for (int i = 0; i < 6; i++) begin
      int p;
      p = vecs[i].port;
      set_req(p, vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].src, vecs[i].tgt);
      req_vld[p] = 1'b1;
      ack_rdy = 2'b11;
      @(negedge clk);
      check("vec_req_rdy", {62'd0, req_rdy}, (p == 1) ? 64'd2 : 64'd1);
      check("vec_mem_en", {63'd0, mem_en}, 64'd1);
      check("vec_mem_wr_en", {63'd0, mem_wr_en}, {63'd0, vecs[i].op});
      check("vec_mem_addr", {32'd0, mem_addr}, {32'd0, vecs[i].addr});
      if (vecs[i].op) begin
        check("vec_mem_wr_data", {32'd0, mem_wr_data}, {32'd0, vecs[i].data});
        check("vec_mem_byte_en", {60'd0, mem_wr_byte_en}, {60'd0, vecs[i].strb});
      end
      tick();
      req_vld[p] = 1'b0;
      wait_ack(p, 8, lat);
      check("vec_latency", lat, vecs[i].op ? 64'd1 : 64'd2);
      check("vec_ack_opcode", {63'd0, ack_op[p]}, {63'd0, vecs[i].op});
      check("vec_ack_data", {32'd0, ack_data[p]}, {32'd0, vecs[i].exp_data});
      check("vec_ack_src_id", {60'd0, ack_src[p]}, {60'd0, vecs[i].tgt});
      check("vec_ack_tgt_id", {60'd0, ack_tgt[p]}, {60'd0, vecs[i].src});
      tick();
      @(negedge clk);
      check("vec_ack_dropped", {62'd0, ack_vld}, 64'd0);
      tick();
    end

    // Both requesters held valid from reset: grants alternate 0,1,0,1 and every access completes
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    base0 = ack_cnt0;
    base1 = ack_cnt1;
    set_req(0, 1'b1, 32'h100, 32'hA0A0A0A0, 4'hF, 4'd1, 4'd2);
    set_req(1, 1'b1, 32'h104, 32'hB1B1B1B1, 4'hF, 4'd3, 4'd4);
    req_vld = 2'b11;
    ack_rdy = 2'b11;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (|req_rdy) begin
          got = 1;
          break;
        end
        tick();
      end
      check("rr_grant_seen", {63'd0, got}, 64'd1);
      check("rr_grant_order", {62'd0, req_rdy}, (k % 2 != 0) ? 64'd2 : 64'd1);
      tick();
      if (k == 3) req_vld = 2'b00;
    end
    repeat (4) tick();
    @(negedge clk);
    check("rr_acks_port0", ack_cnt0 - base0, 64'd2);
    check("rr_acks_port1", ack_cnt1 - base1, 64'd2);
    tick();

    // Read ack stalled by ack_rdy=0 for 5 cycles while in1 waits
    set_req(0, 1'b0, 32'h40, 32'h0, 4'h0, 4'd6, 4'd3);
    req_vld[0] = 1'b1;
    ack_rdy = 2'b00;
    @(negedge clk);
    check("stall_grant0", {62'd0, req_rdy}, 64'd1);
    tick();
    req_vld[0] = 1'b0;
    set_req(1, 1'b0, 32'h44, 32'h0, 4'h0, 4'd2, 4'd1);
    req_vld[1] = 1'b1;
    @(negedge clk);
    check("stall_cap_no_rdy", {62'd0, req_rdy}, 64'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_ack_vld", {62'd0, ack_vld}, 64'd1);
      check("stall_ack_data", {32'd0, ack_data[0]}, 64'hDEAD1234);
      check("stall_ack_ids", {56'd0, ack_src[0], ack_tgt[0]}, 64'h36);
      check("stall_mem_en", {63'd0, mem_en}, 64'd0);
      check("stall_req_rdy", {62'd0, req_rdy}, 64'd0);
      tick();
    end
    ack_rdy[0] = 1'b1;
    @(negedge clk);
    check("stall_release_vld", {62'd0, ack_vld}, 64'd1);
    check("stall_release_no_grant", {62'd0, req_rdy}, 64'd0);
    tick();
    @(negedge clk);
    check("stall_next_grant", {62'd0, req_rdy}, 64'd2);
    tick();
    req_vld[1] = 1'b0;
    ack_rdy[1] = 1'b1;
    wait_ack(1, 6, lat);
    check("stall_in1_latency", lat, 64'd2);
    check("stall_in1_data", {32'd0, ack_data[1]}, 64'hCAFE0000);
    tick();

    // Reset during CAP drops the read; pending in1 request is granted right after
    set_req(0, 1'b0, 32'h40, 32'h0, 4'h0, 4'd1, 4'd1);
    req_vld[0] = 1'b1;
    ack_rdy = 2'b11;
    @(negedge clk);
    check("rstcap_grant0", {62'd0, req_rdy}, 64'd1);
    tick();
    req_vld[0] = 1'b0;
    set_req(1, 1'b1, 32'h48, 32'h55, 4'hF, 4'd9, 4'd10);
    req_vld[1] = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("rstcap_no_rdy", {62'd0, req_rdy}, 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rstcap_in1_grant", {62'd0, req_rdy}, 64'd2);
    check("rstcap_no_ack", {62'd0, ack_vld}, 64'd0);
    check("rstcap_mem_wr_en", {63'd0, mem_wr_en}, 64'd1);
    tick();
    req_vld[1] = 1'b0;
    wait_ack(1, 6, lat);
    check("rstcap_in1_latency", lat, 64'd1);
    check("rstcap_in1_ids", {56'd0, ack_src[1], ack_tgt[1]}, 64'hA9);
    tick();

    // Random traffic against a transaction-level model in an untouched address window
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    ptr = 0;
    granted = 2'b00;
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (granted[p]) req_vld[p] = 1'b0;
        if (!req_vld[p] && cyc < 400 && ($urandom % 2) == 0) begin
          set_req(p, 1'($urandom % 2), 32'h200 + 32'(4 * $urandom_range(7, 0)),
                  $urandom, 4'($urandom), 4'($urandom), 4'($urandom));
          req_vld[p] = 1'b1;
        end
        ack_rdy[p] = (cyc >= 400) ? 1'b1 : (($urandom % 4) != 0);
      end
      granted = 2'b00;
      @(negedge clk);
      if (|req_rdy) begin
        w = (req_vld == 2'b11) ? ptr : (req_vld[1] ? 1 : 0);
        ptr = 1 - w;
        check("rnd_grant", {62'd0, req_rdy}, (w == 1) ? 64'd2 : 64'd1);
        check("rnd_mem_addr", {32'd0, mem_addr}, {32'd0, req_addr[w]});
        check("rnd_mem_wr_en", {63'd0, mem_wr_en}, {63'd0, req_op[w]});
        e.op  = req_op[w];
        e.src = req_tgt[w];
        e.tgt = req_src[w];
        if (req_op[w]) begin
          e.data = '0;
          for (int b = 0; b < SW; b++)
            if (req_strb[w][b]) ref_mem[req_addr[w][9:2]][8*b +: 8] = req_data[w][8*b +: 8];
        end else begin
          e.data = ref_mem[req_addr[w][9:2]];
        end
        if (w == 0) expq0.push_back(e);
        else        expq1.push_back(e);
        granted = req_rdy;
      end
      for (int p = 0; p < 2; p++) begin
        if (ack_vld[p] && ack_rdy[p]) begin
          a = {ack_op[p], ack_data[p], ack_src[p], ack_tgt[p]};
          if ((p == 0 && expq0.size() == 0) || (p == 1 && expq1.size() == 0)) begin
            check("rnd_spurious_ack", {63'd0, ack_vld[p]}, 64'd0);
          end else begin
            e = (p == 0) ? expq0.pop_front() : expq1.pop_front();
            check("rnd_ack", {23'd0, a}, {23'd0, e});
          end
        end
      end
      tick();
    end
    check("rnd_drain0", expq0.size(), 64'd0);
    check("rnd_drain1", expq1.size(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
